// File: rtl/sound_pwm_output.sv
// sound_pwm_output
//   Converts an unsigned audio sample into a pulse-width-modulated speaker
//   drive. A free-running N-bit counter defines the PWM period; once per
//   period (when the counter reaches all-ones) a new sample is captured,
//   scaled by the volume setting and by a soft-start gain g (0..4), and
//   loaded as the duty cycle for the next period. The gain ramps up or down
//   by one step per period so enabling/disabling the output never pops.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   sample_i     unsigned N-bit audio sample (from the sound generator)
//   enable_i     request sound output, level-sensitive
//   volume_i     0 = mute, 1 = sample>>2, 2 = sample>>1, 3 = full scale
//   pwm_o        PWM drive for the speaker pin
//   sample_req_o one-cycle pulse in the cycle sample_i is captured
//   active_o     high whenever the ramp FSM is not idle
module sound_pwm_output #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sample_i,
  input  logic         enable_i,
  input  logic [1:0]   volume_i,
  output logic         pwm_o,
  output logic         sample_req_o,
  output logic         active_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] RAMP_DOWN = 2'd3;

  localparam logic [2:0] G_MAX = 3'd4;

  logic [N-1:0] cnt;
  logic [N-1:0] duty_q;
  logic [2:0]   g;
  logic [1:0]   state;

  logic         boundary;
  logic [2:0]   g_next;
  logic [1:0]   state_next;
  logic [N-1:0] scaled;
  logic [N+2:0] product;
  logic [N-1:0] duty_next;
  logic         unused_product_bits;

  // The last count of each period is the only cycle in which inputs matter.
  assign boundary = (cnt == {N{1'b1}});

  // Gain ramp FSM. RAMP_UP and RAMP_DOWN behave identically for a given
  // enable level; the state only records the direction of the last step.
  // The guards on g keep it inside 0..4 even if it were somehow out of step
  // with the state.
  always_comb begin
    g_next     = g;
    state_next = state;
    case (state)
      IDLE: begin
        if (enable_i) begin
          g_next     = 3'd1;
          state_next = RAMP_UP;
        end else begin
          g_next     = 3'd0;
          state_next = IDLE;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (enable_i) begin
          if (g >= G_MAX - 3'd1) begin
            g_next     = G_MAX;
            state_next = RUN;
          end else begin
            g_next     = g + 3'd1;
            state_next = RAMP_UP;
          end
        end else begin
          if (g <= 3'd1) begin
            g_next     = 3'd0;
            state_next = IDLE;
          end else begin
            g_next     = g - 3'd1;
            state_next = RAMP_DOWN;
          end
        end
      end
      RUN: begin
        if (enable_i) begin
          g_next     = G_MAX;
          state_next = RUN;
        end else begin
          g_next     = G_MAX - 3'd1;
          state_next = RAMP_DOWN;
        end
      end
      default: begin
        g_next     = 3'd0;
        state_next = IDLE;
      end
    endcase
  end

  // Duty for the next period: (volume-scaled sample * g) / 4. The product is
  // kept at full N+3 width so nothing is lost before the final shift; with
  // g <= 4 the shifted result always fits back into N bits.
  always_comb begin
    scaled = '0;
    case (volume_i)
      2'd3:    scaled = sample_i;
      2'd2:    scaled = sample_i >> 1;
      2'd1:    scaled = sample_i >> 2;
      default: scaled = '0;
    endcase
    product   = {3'b000, scaled} * {{N{1'b0}}, g_next};
    duty_next = product[N+1:2];
  end

  assign unused_product_bits = ^{product[N+2], product[1:0]};

  // Counter runs in every state; gain, state and duty only change at the
  // period boundary. Reset wins over a coincident boundary update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      duty_q <= '0;
      g      <= 3'd0;
      state  <= IDLE;
    end else begin
      cnt <= cnt + 1'b1;
      if (boundary) begin
        g      <= g_next;
        state  <= state_next;
        duty_q <= duty_next;
      end
    end
  end

  assign pwm_o        = (cnt < duty_q);
  assign sample_req_o = boundary;
  assign active_o     = (state != IDLE);

endmodule
